// File: rtl/dest_port_arbiter.sv
// Per-destination round-robin scheduler: picks one source, holds it for a whole
// packet, and drives the beats through a registered valid/ready output stage.
module dest_port_arbiter #(
    parameter  int PORT_NUB   = 8,
    parameter  int DATA_WIDTH = 32,
    parameter  int DEST       = 0,
    localparam int WIDTH_SEL  = $clog2(PORT_NUB),
    localparam int BEAT_W     = 2 * WIDTH_SEL + DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [PORT_NUB*BEAT_W-1:0]   req_data,
    input  logic [PORT_NUB-1:0]          req_valid,
    input  logic [PORT_NUB-1:0]          req_last,
    output logic [PORT_NUB-1:0]          grant,
    output logic [BEAT_W-1:0]            out_data,
    output logic [WIDTH_SEL-1:0]         out_src,
    output logic                         out_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         err_dest
);

    typedef enum logic {
        ST_ARB,
        ST_LOCK
    } state_e;

    state_e               state_q,     state_d;
    logic [WIDTH_SEL-1:0] rr_ptr_q,    rr_ptr_d;
    logic [WIDTH_SEL-1:0] lock_src_q,  lock_src_d;
    logic [BEAT_W-1:0]    out_data_q,  out_data_d;
    logic [WIDTH_SEL-1:0] out_src_q,   out_src_d;
    logic                 out_last_q,  out_last_d;
    logic                 out_valid_q, out_valid_d;
    logic                 err_dest_q,  err_dest_d;

    logic                 load;
    logic                 found;
    logic [WIDTH_SEL-1:0] winner;
    logic [WIDTH_SEL-1:0] sel_src;
    logic                 sel_ok;
    logic                 cap_en;
    logic [BEAT_W-1:0]    sel_beat;
    logic [PORT_NUB-1:0]  grant_d;

    // Round-robin search starting at rr_ptr; the first hit wins.
    always_comb begin
        int                   idx;
        logic [WIDTH_SEL-1:0] idx_w;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < PORT_NUB; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= PORT_NUB) idx = idx - PORT_NUB;
            idx_w = WIDTH_SEL'(idx);
            if (!found && req_valid[idx_w]) begin
                found  = 1'b1;
                winner = idx_w;
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_src_d  = lock_src_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        err_dest_d  = err_dest_q;
        grant_d     = '0;

        load     = !out_valid_q || out_ready;
        sel_src  = (state_q == ST_LOCK) ? lock_src_q : winner;
        sel_ok   = (state_q == ST_LOCK) ? req_valid[lock_src_q] : found;
        cap_en   = load && sel_ok;
        sel_beat = req_data[int'(sel_src)*BEAT_W +: BEAT_W];

        if (load) out_valid_d = sel_ok;

        if (cap_en) begin
            grant_d[sel_src] = rst_n;
            out_data_d       = sel_beat;
            out_src_d        = sel_src;
            out_last_d       = req_last[sel_src];
            if (sel_beat[BEAT_W-1 -: WIDTH_SEL] != WIDTH_SEL'(DEST)) err_dest_d = 1'b1;

            if (state_q == ST_ARB) begin
                // The pointer moves once per packet, at its first beat.
                rr_ptr_d = (int'(winner) == PORT_NUB - 1) ? '0 : WIDTH_SEL'(int'(winner) + 1);
                if (!req_last[winner]) begin
                    state_d    = ST_LOCK;
                    lock_src_d = winner;
                end
            end else if (req_last[sel_src]) begin
                state_d = ST_ARB;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!rst_n) begin
            state_q     <= ST_ARB;
            rr_ptr_q    <= '0;
            lock_src_q  <= '0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_dest_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_src_q  <= lock_src_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            err_dest_q  <= err_dest_d;
        end
    end

    assign grant     = grant_d;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign err_dest  = err_dest_q;

endmodule

// File: doc/dest_port_arbiter.md
Name: dest_port_arbiter

Overview:
- Per-destination round-robin scheduler that sits directly behind the destination filter of the switch module; one instance per output port.
- Takes the filtered per-source packet beats and per-source valid flags for destination DEST and picks one source at a time.
- Locks onto the chosen source for a whole multi-beat packet.
- Delivers the beats through a registered valid/ready output stage to the shared-memory write side, and returns a per-source grant pulse so the input queues can advance.

Parameters:
- PORT_NUB, 8, number of switch ports (equals `PORT_NUB_TOTAL); WIDTH_SEL = $clog2(PORT_NUB).
- DATA_WIDTH, 32, payload width (equals `DATA_WIDTH).
- DEST, 0, destination port index this instance serves.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- req_data  in  PORT_NUB*(2*WIDTH_SEL+DATA_WIDTH)  per-source beat; slice i = {rx_port, tx_port, data}, source 0 in the LSB slice.
- req_valid  in  PORT_NUB  per-source beat valid, taken from the filter's valid vector.
- req_last  in  PORT_NUB  per-source last-beat flag; qualified by req_valid.
- grant  out  PORT_NUB  one-hot, combinational; high in the cycle source i's beat is captured.
- out_data  out  2*WIDTH_SEL+DATA_WIDTH  registered beat {rx_port, tx_port, data}.
- out_src  out  WIDTH_SEL  source index of out_data.
- out_last  out  1  registered last flag.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- err_dest  out  1  sticky flag: a captured beat had rx_port != DEST.

Behaviour:
- All outputs are sampled/updated on the rising clk edge.
- Reset (rst_n=0 at an edge):
  - out_valid=0, out_data=0, out_src=0, out_last=0, err_dest=0.
  - rr_ptr=0; state=ARB; grant=0 while rst_n=0.
  - Reset mid-packet abandons the lock; the packet is not resumed.
- Load enable: load = !out_valid || out_ready.
  - The output register holds while out_valid=1 and out_ready=0.
  - No beat is captured and grant stays 0 in that case.
- State ARB:
  - If load and any req_valid: winner = first set bit scanning rr_ptr, rr_ptr+1, ..., PORT_NUB-1, 0, ..., wrapping mod PORT_NUB.
  - grant[winner]=1; slice winner is captured into out_data/out_src/out_last; out_valid<=1.
  - rr_ptr <= (winner+1) mod PORT_NUB.
  - If req_last[winner]=0, go to LOCK with lock_src=winner; otherwise stay in ARB.
  - If load and no req_valid: out_valid<=0 and rr_ptr is unchanged.
- State LOCK:
  - Only lock_src is eligible; all other req_valid bits are ignored and get no grant.
  - If load and req_valid[lock_src]: capture it and pulse grant[lock_src].
  - If that beat has req_last=1, return to ARB. rr_ptr was already advanced at packet start and does not change.
  - If load and !req_valid[lock_src]: out_valid<=0 and stay in LOCK (bubble).
- Timing:
  - Latency: req_valid high at edge N gives out_valid at edge N+1.
  - Throughput is 1 beat/cycle while out_ready=1.
  - An accept (out_valid & out_ready) and a new capture may happen in the same cycle, so there are no bubbles.
- grant is a function of current state, rr_ptr, req_valid and load only. It must never be high when load=0.
- err_dest:
  - Set on any capture whose rx_port != DEST.
  - Cleared only by reset.
  - The beat is still forwarded.
- Single-source case: the same source may win back-to-back packets; rr_ptr wraps from PORT_NUB-1 to 0.

Test Plan:
1. Reset, then req_valid=8'b0000_0101, req_last all 1, out_ready=1.
   - Grants go to src 0 then src 2 on consecutive cycles; out_src 0 then 2, starting one cycle after req.
   - rr_ptr ends at 3.
2. All 8 sources hold valid single-beat requests, out_ready=1 for 16 cycles.
   - Grants cycle 0,1,...,7,0,...; each source gets exactly 2 grants; out_valid stays high continuously.
3. src 3 sends a 4-beat packet (last on beat 4) while src 5 is continuously valid.
   - 4 consecutive grants to src 3, then src 5; no src 5 grant during the lock.
   - Drop req_valid[3] for 2 cycles mid-packet -> 2 cycles of out_valid=0, still locked.
4. out_ready=0 for 5 cycles with out_valid=1 and requests pending.
   - out_data stable, grant=0 throughout.
   - First out_ready=1 cycle: accept and new capture in the same cycle.
5. Inject a beat with rx_port=2 into an instance with DEST=0.
   - err_dest=1 from the next cycle and stays set; the beat is still forwarded.
6. Assert rst_n=0 for one edge during LOCK on src 6, then src 1 requests.
   - out_valid=0 after reset; src 1 is granted and the lock on src 6 is gone.
